// File: rtl/fast_n_type_encoder_if.sv
// Field-request / encoded-byte bundle for fast_n_type_encoder.
// The encoder takes the slave view; the message builder and byte packer take the master view.
interface fast_n_type_encoder_if #(
    parameter int MSG_BITS = 64,
    parameter int LEN_BITS = 4
);
    logic                in_valid;
    logic                in_ready;
    logic [2:0]          in_type;
    logic [MSG_BITS-1:0] in_value;
    logic                out_valid;
    logic                out_ready;
    logic [7:0]          out_byte;
    logic                out_last;
    logic [LEN_BITS-1:0] out_length;
    logic                err_type;

    modport master (
        output in_valid, in_type, in_value, out_ready,
        input  in_ready, out_valid, out_byte, out_last, out_length, err_type
    );

    modport slave (
        input  in_valid, in_type, in_value, out_ready,
        output in_ready, out_valid, out_byte, out_last, out_length, err_type
    );
endinterface

// File: rtl/fast_n_type_encoder.sv
// FAST stop-bit encoder for N-type integers: one field in, 1..10 bytes out, MS group first.
// FAST_NULLABLE_EN enables nullable uint64 (type S, value+1) and widens the working register to 65 bits.
module fast_n_type_encoder #(
    parameter int MSG_BITS = 64,
    parameter int LEN_BITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fast_n_type_encoder_if.slave  bus
);

`ifdef FAST_NULLABLE_EN
    localparam int WORK_BITS = 65;
`else
    localparam int WORK_BITS = 64;
`endif
    localparam int GROUPS   = 10;
    localparam int EXT_BITS = 7 * GROUPS;

    typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;

    state_t                 state_reg;
    logic [WORK_BITS-1:0]   working_reg;
    logic                   signed_reg;
    logic [3:0]             index_reg;
    logic                   out_valid_reg;
    logic [7:0]             out_byte_reg;
    logic                   out_last_reg;
    logic [LEN_BITS-1:0]    out_length_reg;
    logic                   err_type_reg;

    logic [63:0]            value64;
    logic [WORK_BITS-1:0]   latch_value;
    logic                   latch_signed;
    logic                   latch_supported;

    logic [EXT_BITS-1:0]    ext_value;
    logic [6:0]             group [GROUPS];
    logic [WORK_BITS-1:0]   mag;
    logic [6:0]             bit_len;
    logic [6:0]             eff_len;
    logic [GROUPS-1:0]      len_hit;
    logic [3:0]             group_count;
    logic [3:0]             first_index;
    logic [3:0]             next_index;

    assign value64 = 64'(bus.in_value);

    // Extend the request into the working register according to its type.
    always_comb begin
        latch_value     = '0;
        latch_signed    = 1'b0;
        latch_supported = 1'b1;
        case (bus.in_type)
            3'd0: latch_value = WORK_BITS'(value64[31:0]);
            3'd1: begin
                latch_value  = {{(WORK_BITS-32){value64[31]}}, value64[31:0]};
                latch_signed = 1'b1;
            end
            3'd2: latch_value = WORK_BITS'(value64);
            3'd3: begin
                latch_value  = {{(WORK_BITS-63){value64[63]}}, value64[62:0]};
                latch_signed = 1'b1;
            end
`ifdef FAST_NULLABLE_EN
            3'd4: latch_value = {1'b0, value64} + 65'd1;
`endif
            default: latch_supported = 1'b0;
        endcase
    end

    // Bits above the working register are sign replicas for signed types, else zero.
    assign ext_value = {{(EXT_BITS-WORK_BITS){signed_reg & working_reg[WORK_BITS-1]}}, working_reg};

    genvar gi;
    generate
        for (gi = 0; gi < GROUPS; gi++) begin : g_group
            assign group[gi] = ext_value[7*gi +: 7];
        end
    endgenerate

    // Negative values are measured by their complement; the sign needs one extra bit.
    assign mag = (signed_reg && working_reg[WORK_BITS-1]) ? ~working_reg : working_reg;

    always_comb begin
        bit_len = '0;
        for (int i = 0; i < WORK_BITS; i++) begin
            if (mag[i]) begin
                bit_len = 7'(i + 1);
            end
        end
    end

    always_comb begin
        eff_len = bit_len;
        if (signed_reg) begin
            eff_len = bit_len + 7'd1;
        end else if (bit_len == 7'd0) begin
            eff_len = 7'd1;
        end
    end

    // ceil(eff_len / 7) as a count of group boundaries the length crosses.
    generate
        for (gi = 0; gi < GROUPS; gi++) begin : g_hit
            assign len_hit[gi] = (eff_len > 7'(7 * gi));
        end
    endgenerate

    always_comb begin
        group_count = '0;
        for (int i = 0; i < GROUPS; i++) begin
            group_count = group_count + 4'(len_hit[i]);
        end
    end

    assign first_index = group_count - 4'd1;
    assign next_index  = index_reg - 4'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            working_reg    <= '0;
            signed_reg     <= 1'b0;
            index_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_byte_reg   <= '0;
            out_last_reg   <= 1'b0;
            out_length_reg <= '0;
            err_type_reg   <= 1'b0;
        end else begin
            err_type_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.in_valid) begin
                        working_reg  <= latch_value;
                        signed_reg   <= latch_signed;
                        // Registered here so the pulse lines up with the CALC cycle.
                        err_type_reg <= ~latch_supported;
                        state_reg    <= CALC;
                    end
                end
                CALC: begin
                    if (err_type_reg) begin
                        state_reg <= IDLE;
                    end else begin
                        index_reg      <= first_index;
                        out_length_reg <= LEN_BITS'(group_count);
                        out_valid_reg  <= 1'b1;
                        out_last_reg   <= (first_index == 4'd0);
                        out_byte_reg   <= {first_index == 4'd0, group[first_index]};
                        state_reg      <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (out_last_reg) begin
                            out_valid_reg  <= 1'b0;
                            out_byte_reg   <= '0;
                            out_last_reg   <= 1'b0;
                            out_length_reg <= '0;
                            state_reg      <= IDLE;
                        end else begin
                            index_reg    <= next_index;
                            out_last_reg <= (next_index == 4'd0);
                            out_byte_reg <= {next_index == 4'd0, group[next_index]};
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_reg == IDLE);
    assign bus.out_valid  = out_valid_reg;
    assign bus.out_byte   = out_byte_reg;
    assign bus.out_last   = out_last_reg;
    assign bus.out_length = out_length_reg;
    assign bus.err_type   = err_type_reg;

endmodule

// File: tb/tb_fast_n_type_encoder.sv
// Randomised and directed bench for fast_n_type_encoder against an arithmetic model of the FAST N-type encoding.
module tb_fast_n_type_encoder;

    localparam int MSG_BITS = 64;
    localparam int LEN_BITS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fast_n_type_encoder_if #(.MSG_BITS(MSG_BITS), .LEN_BITS(LEN_BITS)) bus ();

    fast_n_type_encoder #(.MSG_BITS(MSG_BITS), .LEN_BITS(LEN_BITS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] exp_bytes [10];
    int         exp_n;
    bit         exp_err;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: treat the field as a mathematical integer, find the smallest group count
    // whose range holds it, then slice 7-bit groups MS first.
    task automatic model(input logic [2:0] t, input logic [63:0] v);
        logic signed [79:0] sv;
        logic signed [79:0] lim;
        bit is_signed;
        bit found;
        exp_err   = 1'b0;
        is_signed = 1'b0;
        sv        = '0;
        case (t)
            3'd0: sv = {48'd0, v[31:0]};
            3'd1: begin sv = {{48{v[31]}}, v[31:0]}; is_signed = 1'b1; end
            3'd2: sv = {16'd0, v};
            3'd3: begin sv = {{16{v[63]}}, v}; is_signed = 1'b1; end
`ifdef FAST_NULLABLE_EN
            3'd4: sv = {16'd0, v} + 80'sd1;
`endif
            default: exp_err = 1'b1;
        endcase
        exp_n = 0;
        found = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (!found) begin
                lim = 80'sd1 <<< (is_signed ? 7 * n - 1 : 7 * n);
                if (is_signed ? (sv >= -lim && sv < lim) : (sv < lim)) begin
                    exp_n = n;
                    found = 1'b1;
                end
            end
        end
        for (int i = 0; i < exp_n; i++) begin
            logic signed [79:0] sh;
            sh = sv >>> (7 * (exp_n - 1 - i));
            exp_bytes[i] = {i == exp_n - 1, sh[6:0]};
        end
    endtask

    // mode 0: always ready, 1: ready toggles 1/0, 2: random ready
    task automatic run_field(input logic [2:0] t, input logic [63:0] v, input int mode);
        int idx;
        int guard;
        int phase;
        bit rdy;
        model(t, v);
        $display("field type=%0d value=0x%016h mode=%0d bytes=%0d err=%0d", t, v, mode, exp_n, exp_err);
        check_eq("in_ready_idle", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_type  = t;
        bus.in_value = v;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("calc_out_valid", bus.out_valid, 0);
        check_eq("calc_in_ready", bus.in_ready, 0);
        check_eq("calc_err_type", bus.err_type, exp_err);
        @(posedge clk); #1;
        if (exp_err) begin
            check_eq("err_clear", bus.err_type, 0);
            check_eq("err_in_ready", bus.in_ready, 1);
            check_eq("err_no_output", bus.out_valid, 0);
        end else begin
            idx = 0;
            guard = 0;
            phase = 0;
            while (idx < exp_n && guard < 200) begin
                rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (phase % 2 == 0) : ($urandom_range(0, 3) != 0);
                phase++;
                bus.out_ready = rdy;
                check_eq("out_valid", bus.out_valid, 1);
                check_eq("out_byte", bus.out_byte, exp_bytes[idx]);
                check_eq("out_last", bus.out_last, (idx == exp_n - 1));
                check_eq("out_length", bus.out_length, exp_n);
                check_eq("emit_in_ready", bus.in_ready, 0);
                @(posedge clk); #1;
                if (rdy) idx++;
                guard++;
            end
            check_eq("emit_bytes_done", idx, exp_n);
            bus.out_ready = 1'b0;
            check_eq("done_out_valid", bus.out_valid, 0);
            check_eq("done_in_ready", bus.in_ready, 1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] v;
        logic [2:0]  t;
        bus.in_valid  = 1'b0;
        bus.in_type   = '0;
        bus.in_value  = '0;
        bus.out_ready = 1'b0;

        #12;
        check_eq("rst_in_ready", bus.in_ready, 1);
        check_eq("rst_out_valid", bus.out_valid, 0);
        check_eq("rst_out_byte", bus.out_byte, 0);
        check_eq("rst_out_length", bus.out_length, 0);
        check_eq("rst_err_type", bus.err_type, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases from the encoding rules and boundaries.
        run_field(3'd0, 64'd0, 0);
        run_field(3'd2, 64'd942755, 0);
        run_field(3'd1, 64'h0000_0000_FFFF_FFFF, 0);
        run_field(3'd1, 64'd64, 0);
        run_field(3'd1, 64'h0000_0000_FFFF_FFC0, 0);
        run_field(3'd2, 64'hFFFF_FFFF_FFFF_FFFF, 1);
        run_field(3'd3, 64'h7FFF_FFFF_FFFF_FFFF, 0);
        run_field(3'd3, 64'h8000_0000_0000_0000, 0);
        run_field(3'd4, 64'd0, 0);
        run_field(3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run_field(3'd7, 64'd123, 0);
        run_field(3'd5, 64'd0, 0);

        // New request arriving during the final-byte handshake waits one IDLE cycle.
        $display("field overlap: type=0 value=5 requested during last byte of previous field");
        bus.in_valid = 1'b1;
        bus.in_type  = 3'd0;
        bus.in_value = 64'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        check_eq("ovl_first_byte", bus.out_byte, 8'h85);
        @(posedge clk); #1;
        check_eq("ovl_not_accepted", bus.in_ready, 1);
        check_eq("ovl_idle_out_valid", bus.out_valid, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check_eq("ovl_accepted", bus.in_ready, 0);
        @(posedge clk); #1;
        check_eq("ovl_second_valid", bus.out_valid, 1);
        check_eq("ovl_second_byte", bus.out_byte, 8'h85);
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_eq("ovl_done", bus.in_ready, 1);

        // Asynchronous reset during the 3rd byte of a 10-byte field.
        $display("field reset: type=2 value=0xffffffffffffffff reset during byte 3");
        bus.in_valid = 1'b1;
        bus.in_type  = 3'd2;
        bus.in_value = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("rst_mid_byte3", bus.out_byte, 8'h7F);
        #1 rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", bus.out_valid, 0);
        check_eq("arst_out_byte", bus.out_byte, 0);
        check_eq("arst_out_last", bus.out_last, 0);
        check_eq("arst_out_length", bus.out_length, 0);
        check_eq("arst_err_type", bus.err_type, 0);
        check_eq("arst_in_ready", bus.in_ready, 1);
        bus.out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_field(3'd3, 64'hFFFF_FFFF_FFFF_FF00, 0);

        // Randomised fields with random backpressure.
        for (int k = 0; k < 150; k++) begin
            v = {$urandom(), $urandom()};
            v = v >> $urandom_range(0, 63);
            if ($urandom_range(0, 1) == 1) v = ~v;
            t = 3'($urandom_range(0, 7));
            run_field(t, v, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fast_n_type_encoder.md
# fast_n_type_encoder

FAST stop-bit encoder for N-type integer fields, and the transmit-side counterpart of the stage-3 N-type decode select. It accepts one binary field value plus its N-type code and emits the FAST wire encoding one byte per cycle:
- 7-bit groups, most significant group first;
- bit 7 is the stop bit and is set only on the final byte.

It sits between the order/quote message builder and the outbound byte packer.

## Interface
- `MSG_BITS`, default 64: width of `in_value`; matches the codebase fast message width.
- `LEN_BITS`, default 4: width of `out_length`; must hold 10.
- `clk`, input, 1: the single clock; all state is updated on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: field request valid.
- `in_ready`, output, 1: encoder can accept a field.
- `in_type`, input, 3: N-type code.
  - L=0: uint32. M=1: int32. N=2: uint64. R=3: int64. S=4: nullable uint64.
- `in_value`, input, `MSG_BITS`: field value.
  - For types L and M only bits [31:0] are used.
  - For type M, bit 31 is the sign.
- `out_valid`, output, 1: `out_byte` valid.
- `out_ready`, input, 1: downstream accepts the byte.
- `out_byte`, output, 8: encoded byte.
- `out_last`, output, 1: high on the final byte of a field (equal to `out_byte[7]`).
- `out_length`, output, `LEN_BITS`: total byte count of the current field, 1..10; stable while in EMIT.
- `err_type`, output, 1: one-cycle pulse when an unsupported type is accepted.

## Operation
- The FSM has three states: IDLE, CALC and EMIT.
- `in_ready` = (state == IDLE). It is combinational from state only.
- **IDLE:** on `in_valid && in_ready`, latch the type and value into a 65-bit working register, then go to CALC.
  - Types L and N are zero-extended.
  - Types M and R are sign-extended; M extends from bit 31.
  - Type S stores value+1 in 65 bits. 0xFFFF_FFFF_FFFF_FFFF therefore becomes 2^64 with no wrap.
- **CALC:** one cycle. Compute the group count n, load `out_length` = n and the byte index, then go to EMIT.
  - Unsigned types: n = max(1, ceil(bitlen/7)).
  - Signed types: n is the minimum such that the value fits in a 7n-bit two's-complement number. Example: +64 needs 2 groups; −64 needs 1.
  - If the type code is unsupported: pulse `err_type`, emit nothing, return to IDLE.
- **EMIT:** `out_valid` = 1.
  - `out_byte` = {stop, group[index]}, where stop = (index == 0).
  - On `out_valid && out_ready`: decrement index. If the byte just accepted had `out_last`, go to IDLE.
  - While `out_ready` = 0, `out_byte`, `out_last` and `out_length` hold stable.
- Group arithmetic: group k = working[7k+6:7k]. Bits above bit 64 are sign replicas for signed types and 0 otherwise.
- Maximum field length is 10 bytes, for both 65-bit unsigned and 64-bit signed values.

## Timing
- A field accepted at cycle t raises `out_valid` at t+2, with the first byte on `out_byte`.
- One byte is transferred per cycle while `out_ready` = 1.
- Per-field occupancy is n + 2 cycles with no stalls. There is no back-to-back overlap: `in_ready` is low from CALC through the final byte handshake.
- `err_type` is high for exactly the CALC cycle of an unsupported type. `in_ready` rises the next cycle.
- Reset asserted at any time, including mid-EMIT, takes effect immediately:
  - state goes to IDLE;
  - `out_valid`, `out_byte`, `out_last`, `out_length` and `err_type` go to 0;
  - `in_ready` = 1;
  - any partially sent field is discarded.
- Simultaneous `in_valid` and a final-byte handshake: the new field is not accepted that cycle and is accepted the following IDLE cycle.

## Configuration
- Macro `FAST_NULLABLE_EN`.
- Defined: type S is supported; the value+1 path and the 65-bit working register are present.
- Undefined: the +1 adder is compiled out, and the working register may be 64 bits. Type S is treated as unsupported, like codes 5–7: it is accepted, `err_type` pulses, and no bytes are emitted.

## Test plan
- uint32 (L), value 0 -> single byte 0x80, `out_length` = 1, `out_last` = 1; first `out_valid` two cycles after acceptance.
- uint64 (N), value 942755 -> bytes 0x39, 0x45, 0xA3; `out_length` = 3; `out_last` only on 0xA3.
- int32 (M) -> value 0xFFFF_FFFF (−1) gives 0xFF; value 64 gives 0x00, 0xC0; value 0xFFFF_FFC0 (−64) gives 0xC0.
- uint64 (N), value 0xFFFF_FFFF_FFFF_FFFF, with `out_ready` toggled 1/0 each cycle -> 0x01, then eight bytes of 0x7F, then 0xFF. Each byte is held while stalled, and `out_length` = 10 throughout.
- Nullable type S:
  - With `FAST_NULLABLE_EN`: value 0 gives 0x81; value 0xFFFF_FFFF_FFFF_FFFF gives 0x02 followed by nine bytes of 0x00 with the last being 0x80.
  - Without the macro: `err_type` pulses once and `out_valid` stays 0.
- Type 7 -> one-cycle `err_type`, `in_ready` back at t+2. Separately: `rst_n` low during the 3rd byte of a 10-byte field -> all outputs go to 0 asynchronously, and the next field encodes correctly after release.
